// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcode encodings,
// write-back constants and the divider FSM state encoding.
package ex_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RegAddrW = 5;

    localparam logic [XLEN-1:0]     ZeroWord     = '0;
    localparam logic                WriteDisable = 1'b0;
    localparam logic [RegAddrW-1:0] ZeroReg      = '0;

    localparam logic [7:0] AluNop    = 8'h00;
    localparam logic [7:0] AluAdd    = 8'h01;
    localparam logic [7:0] AluSub    = 8'h02;
    localparam logic [7:0] AluSll    = 8'h03;
    localparam logic [7:0] AluSlt    = 8'h04;
    localparam logic [7:0] AluSltu   = 8'h05;
    localparam logic [7:0] AluXor    = 8'h06;
    localparam logic [7:0] AluSrl    = 8'h07;
    localparam logic [7:0] AluSra    = 8'h08;
    localparam logic [7:0] AluOr     = 8'h09;
    localparam logic [7:0] AluAnd    = 8'h0a;
    localparam logic [7:0] AluMul    = 8'h10;
    localparam logic [7:0] AluMulh   = 8'h11;
    localparam logic [7:0] AluMulhsu = 8'h12;
    localparam logic [7:0] AluMulhu  = 8'h13;
    localparam logic [7:0] AluDiv    = 8'h20;
    localparam logic [7:0] AluDivu   = 8'h21;
    localparam logic [7:0] AluRem    = 8'h22;
    localparam logic [7:0] AluRemu   = 8'h23;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == AluDiv) || (op == AluDivu) || (op == AluRem) || (op == AluRemu);
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Serial restoring divider on unsigned magnitudes with its own IDLE/BUSY/DONE
// sequencing. Special cases (fast_i) resolve in a single BUSY cycle.
module ex_stage_div_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            fast_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [1:0]      state_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    import ex_stage_pkg::*;

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            fast_q, fast_d;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        fast_d    = fast_q;
        rem_shift = {rem_q, quot_q[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_q};

        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d   = StBusy;
                        cnt_d     = '0;
                        quot_d    = dividend_i;
                        rem_d     = '0;
                        divisor_d = divisor_i;
                        fast_d    = fast_i;
                    end
                end
                StBusy: begin
                    if (fast_q) begin
                        // Dividend still sits in the quotient register here.
                        state_d = StDone;
                        if (divisor_q == '0) begin
                            quot_d = '1;
                            rem_d  = quot_q;
                        end else begin
                            rem_d  = '0;
                        end
                    end else begin
                        rem_d  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], ~trial[XLEN]};
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            fast_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            fast_q    <= fast_d;
        end
    end

    assign state_o     = state_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and multiplier, plus sign handling and
// pipeline stall control around the iterative divider.
module ex_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [XLEN-1:0]                    op1_i,
    input  logic [XLEN-1:0]                    op2_i,
    input  logic                               reg_we_i,
    input  logic [ex_stage_pkg::RegAddrW-1:0]  reg_waddr_i,
    input  logic [7:0]                         aluOp_i,
    input  logic                               flush_i,
    output logic [XLEN-1:0]                    wdata_o,
    output logic                               reg_we_o,
    output logic [ex_stage_pkg::RegAddrW-1:0]  reg_waddr_o,
    output logic                               stall_o
);
    import ex_stage_pkg::*;

    logic [XLEN-1:0]     alu_res;
    logic [2*XLEN-1:0]   op1_ext, op2_ext, prod;
    logic                mul_s1, mul_s2;
    logic                is_div, div_signed, div_special, div_start;
    logic [XLEN-1:0]     mag1, mag2, quotient, remainder, div_res;
    logic [1:0]          div_state;
    logic [7:0]          op_q;
    logic [RegAddrW-1:0] waddr_q;
    logic                we_q, quot_neg_q, rem_neg_q;

    // One full-width multiplier serves all four MUL variants via operand extension.
    assign mul_s1  = (aluOp_i == AluMulh) || (aluOp_i == AluMulhsu);
    assign mul_s2  = (aluOp_i == AluMulh);
    assign op1_ext = {{XLEN{op1_i[XLEN-1] & mul_s1}}, op1_i};
    assign op2_ext = {{XLEN{op2_i[XLEN-1] & mul_s2}}, op2_i};
    assign prod    = op1_ext * op2_ext;

    always_comb begin
        alu_res = '0;
        case (aluOp_i)
            AluAdd:    alu_res = op1_i + op2_i;
            AluSub:    alu_res = op1_i - op2_i;
            AluSll:    alu_res = op1_i << op2_i[4:0];
            AluSlt:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            AluSltu:   alu_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            AluXor:    alu_res = op1_i ^ op2_i;
            AluSrl:    alu_res = op1_i >> op2_i[4:0];
            AluSra:    alu_res = $unsigned($signed(op1_i) >>> op2_i[4:0]);
            AluOr:     alu_res = op1_i | op2_i;
            AluAnd:    alu_res = op1_i & op2_i;
            AluMul:    alu_res = prod[XLEN-1:0];
            AluMulh,
            AluMulhsu,
            AluMulhu:  alu_res = prod[2*XLEN-1:XLEN];
            default:   alu_res = '0;
        endcase
    end

    assign is_div      = is_div_op(aluOp_i);
    assign div_signed  = (aluOp_i == AluDiv) || (aluOp_i == AluRem);
    assign mag1        = (div_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign mag2        = (div_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;
    assign div_special = (op2_i == '0) ||
                         (div_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1));
    assign div_start   = is_div && !flush_i && (div_state == StIdle);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q       <= AluNop;
            waddr_q    <= ZeroReg;
            we_q       <= WriteDisable;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else if (div_start) begin
            op_q       <= aluOp_i;
            waddr_q    <= reg_waddr_i;
            we_q       <= reg_we_i;
            // Divide-by-zero must yield all ones regardless of the dividend sign.
            quot_neg_q <= (aluOp_i == AluDiv) && (op1_i[XLEN-1] ^ op2_i[XLEN-1]) &&
                          (op2_i != '0);
            rem_neg_q  <= (aluOp_i == AluRem) && op1_i[XLEN-1];
        end
    end

    ex_stage_div_iter #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_iter (
        .clk_i       (clk_i),
        .rst_ni      (rst_i),
        .start_i     (div_start),
        .fast_i      (div_special),
        .flush_i     (flush_i),
        .dividend_i  (mag1),
        .divisor_i   (mag2),
        .state_o     (div_state),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_comb begin
        if ((op_q == AluRem) || (op_q == AluRemu)) begin
            div_res = rem_neg_q ? -remainder : remainder;
        end else begin
            div_res = quot_neg_q ? -quotient : quotient;
        end
    end

    always_comb begin
        wdata_o     = alu_res;
        reg_we_o    = (aluOp_i == AluNop) ? WriteDisable : reg_we_i;
        reg_waddr_o = reg_waddr_i;
        stall_o     = 1'b0;
        if (!rst_i) begin
            wdata_o     = XLEN'(ZeroWord);
            reg_we_o    = WriteDisable;
            reg_waddr_o = ZeroReg;
        end else if (flush_i) begin
            reg_we_o = WriteDisable;
        end else if (div_state == StBusy) begin
            wdata_o     = XLEN'(ZeroWord);
            reg_we_o    = WriteDisable;
            reg_waddr_o = waddr_q;
            stall_o     = 1'b1;
        end else if (div_state == StDone) begin
            wdata_o     = div_res;
            reg_we_o    = we_q;
            reg_waddr_o = waddr_q;
        end else if (is_div) begin
            wdata_o  = XLEN'(ZeroWord);
            reg_we_o = WriteDisable;
            stall_o  = 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized ALU
// and divide traffic checked against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        we_i = 1'b0;
    logic [4:0]  wa_i = '0;
    logic [7:0]  alu_op = AluNop;
    logic        flush = 1'b0;
    logic [31:0] wdata;
    logic        we_o;
    logic [4:0]  wa_o;
    logic        stall;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    ex_stage #(
        .XLEN       (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .op1_i       (op1),
        .op2_i       (op2),
        .reg_we_i    (we_i),
        .reg_waddr_i (wa_i),
        .aluOp_i     (alu_op),
        .flush_i     (flush),
        .wdata_o     (wdata),
        .reg_we_o    (we_o),
        .reg_waddr_o (wa_o),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            AluAdd:    p = ua + ub;
            AluSub:    p = ua - ub;
            AluSll:    p = ua << b[4:0];
            AluSlt:    p = (sa < sb) ? 64'd1 : 64'd0;
            AluSltu:   p = (ua < ub) ? 64'd1 : 64'd0;
            AluXor:    p = ua ^ ub;
            AluSrl:    p = ua >> b[4:0];
            AluSra:    p = sa >>> b[4:0];
            AluOr:     p = ua | ub;
            AluAnd:    p = ua & ub;
            AluMul:    p = ua * ub;
            AluMulh:   p = (sa * sb) >> 32;
            AluMulhsu: p = (sa * longint'(ub)) >> 32;
            AluMulhu:  p = (ua * ub) >> 32;
            AluDiv: begin
                if (b == 0) p = 64'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = ua;
                else p = sa / sb;
            end
            AluDivu:   p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            AluRem: begin
                if (b == 0) p = ua;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            AluRemu:   p = (b == 0) ? ua : ua % ub;
            default:   p = '0;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_special(input logic [7:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) ||
               ((op == AluDiv || op == AluRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] wa);
        alu_op = op;
        op1    = a;
        op2    = b;
        we_i   = we;
        wa_i   = wa;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Issues one divide in IDLE and follows it to its result cycle.
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wa, output int done_cyc);
        int          stalls;
        int          exp_stalls;
        logic [31:0] exp;
        exp        = ref_result(op, a, b);
        exp_stalls = is_special(op, a, b) ? 2 : 33;
        drive(op, a, b, 1'b1, wa);
        stalls = 0;
        @(negedge clk);
        while (stall === 1'b1 && stalls < 100) begin
            checks++;
            if (we_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_we_during_stall: cycle %0d got %b expected 0", name, stalls, we_o);
            end
            stalls++;
            next_cycle();
            @(negedge clk);
        end
        done_cyc = cycle;
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (wdata !== exp) begin
            errors++;
            $display("FAIL %s_wdata: got %h expected %h", name, wdata, exp);
        end
        checks++;
        if (we_o !== 1'b1 || wa_o !== wa) begin
            errors++;
            $display("FAIL %s_wb: got we=%b wa=%0d expected we=1 wa=%0d", name, we_o, wa_o, wa);
        end
        next_cycle();
    endtask

    task automatic test_reset;
        drive(AluAdd, 32'd1, 32'd2, 1'b1, 5'd5);
        @(negedge clk);
        checks++;
        if (wdata !== 32'h0 || we_o !== 1'b0 || wa_o !== 5'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got wdata=%h we=%b wa=%0d stall=%b expected all 0",
                     wdata, we_o, wa_o, stall);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_directed;
        logic [7:0]  ops [2] = '{AluAdd, AluSra};
        logic [31:0] as  [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [2] = '{32'd1, 32'd4};
        logic [31:0] exps[2] = '{32'h8000_0000, 32'hF800_0000};
        for (int i = 0; i < 2; i++) begin
            drive(ops[i], as[i], bs[i], 1'b1, 5'd1 + 5'(i));
            @(negedge clk);
            checks++;
            if (wdata !== exps[i] || stall !== 1'b0 || we_o !== 1'b1) begin
                errors++;
                $display("FAIL alu_directed_%0d: got wdata=%h stall=%b we=%b expected %h 0 1",
                         i, wdata, stall, we_o, exps[i]);
            end
            next_cycle();
        end
        drive(AluMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd9);
        @(negedge clk);
        checks++;
        if (wdata !== 32'hFFFF_FFFE || stall !== 1'b0) begin
            errors++;
            $display("FAIL mulhu: got %h stall=%b expected fffffffe 0", wdata, stall);
        end
        next_cycle();
    endtask

    task automatic test_alu_random;
        logic [7:0]  ops [15] = '{AluNop, AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
                                  AluSrl, AluSra, AluOr, AluAnd, AluMul, AluMulh, AluMulhsu,
                                  AluMulhu};
        logic [7:0]  op;
        logic [31:0] a, b, exp;
        logic        we;
        logic [4:0]  wa;
        for (int i = 0; i < 60; i++) begin
            op  = ops[$urandom_range(0, 14)];
            a   = $urandom;
            b   = $urandom;
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            exp = ref_result(op, a, b);
            drive(op, a, b, we, wa);
            @(negedge clk);
            checks++;
            if (wdata !== exp || we_o !== (we && op != AluNop) || wa_o !== wa || stall !== 1'b0)
            begin
                errors++;
                $display("FAIL alu_random op=%h a=%h b=%h: got %h we=%b wa=%0d st=%b expected %h %b %0d 0",
                         op, a, b, wdata, we_o, wa_o, stall, exp, we && op != AluNop, wa);
            end
            next_cycle();
        end
    endtask

    task automatic test_div_directed;
        int d;
        run_div("div_neg7_2", AluDiv, 32'hFFFF_FFF9, 32'd2, 5'd10, d);
        run_div("rem_neg7_2", AluRem, 32'hFFFF_FFF9, 32'd2, 5'd11, d);
        run_div("divu_by_zero", AluDivu, 32'd5, 32'd0, 5'd12, d);
        run_div("rem_overflow", AluRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, d);
        run_div("div_overflow", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, d);
        run_div("rem_neg_by_zero", AluRem, 32'hFFFF_FF00, 32'd0, 5'd15, d);
        run_div("div_neg_by_zero", AluDiv, 32'hFFFF_FF00, 32'd0, 5'd16, d);
    endtask

    task automatic test_div_random;
        logic [7:0]  ops [4] = '{AluDiv, AluDivu, AluRem, AluRemu};
        logic [31:0] a, b;
        int          d;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
            run_div("div_random", ops[$urandom_range(0, 3)], a, b, 5'($urandom_range(1, 31)), d);
        end
    endtask

    task automatic test_back_to_back;
        int c0, d1, d2;
        c0 = cycle;
        run_div("b2b_first", AluDiv, 32'd1000, 32'hFFFF_FFF9, 5'd20, d1);
        run_div("b2b_second", AluDiv, 32'hFFFF_0000, 32'd3, 5'd21, d2);
        checks++;
        if (d2 - c0 != 67) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected 67", d2 - c0);
        end
    endtask

    task automatic test_flush;
        drive(AluDivu, 32'd100, 32'd7, 1'b1, 5'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b1 || we_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_pre cycle %0d: got stall=%b we=%b expected 1 0", c, stall, we_o);
            end
            next_cycle();
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got stall=%b we=%b expected 0 0", stall, we_o);
        end
        next_cycle();
        flush = 1'b0;
        drive(AluAdd, 32'd10, 32'd20, 1'b1, 5'd4);
        @(negedge clk);
        checks++;
        if (wdata !== 32'd30 || we_o !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_add: got %h we=%b stall=%b expected 0000001e 1 0",
                     wdata, we_o, stall);
        end
        next_cycle();
        drive(AluAdd, 32'd1, 32'd1, 1'b0, 5'd9);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (we_o !== 1'b0 || stall !== 1'b0 || wa_o !== 5'd9) begin
                errors++;
                $display("FAIL flush_killed cycle %0d: got we=%b stall=%b wa=%0d expected 0 0 9",
                         c, we_o, stall, wa_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_div;
        drive(AluDiv, 32'hFFFF_FF9C, 32'd3, 1'b1, 5'd7);
        for (int c = 0; c < 15; c++) next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (wdata !== 32'h0 || we_o !== 1'b0 || wa_o !== 5'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: got wdata=%h we=%b wa=%0d stall=%b expected all 0",
                     wdata, we_o, wa_o, stall);
        end
        next_cycle();
        rst = 1'b1;
        drive(AluAdd, 32'd3, 32'd4, 1'b1, 5'd8);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (wdata !== 32'd7 || we_o !== 1'b1 || wa_o !== 5'd8 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_then_add cycle %0d: got %h we=%b wa=%0d st=%b expected 7 1 8 0",
                         c, wdata, we_o, wa_o, stall);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div_directed();
        test_div_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RISC-V core. It consumes the operands, ALU opcode and write-back controls registered by the ID/EXE pipeline register and produces the write-back data for the EXE/MEM register. Base ALU and MUL ops finish in one cycle. DIV/DIVU/REM/REMU run on an iterative radix-2 divider, and the block stalls the front of the pipeline until the result is ready.

## Interface
Parameters:
- XLEN, 32, datapath width
- DIV_CYCLES, 32, iterations of the serial divider (equals XLEN)

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-low
- op1_i  in  XLEN  operand 1 from ID/EXE
- op2_i  in  XLEN  operand 2 from ID/EXE
- reg_we_i  in  1  write-back enable from ID/EXE
- reg_waddr_i  in  5  destination register from ID/EXE
- aluOp_i  in  8  ALU opcode (shared package encoding)
- flush_i  in  1  kill the instruction in EXE (branch/trap redirect)
- wdata_o  out  XLEN  result to EXE/MEM
- reg_we_o  out  1  write-back enable to EXE/MEM
- reg_waddr_o  out  5  destination register to EXE/MEM
- stall_o  out  1  hold PC, IF/ID and ID/EXE; EXE/MEM takes a bubble

## Operation
- Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, NOP.
  - Result is combinational from the inputs; shift amount is op2_i[4:0].
  - reg_we_o = reg_we_i and reg_waddr_o = reg_waddr_i.
  - NOP gives wdata_o = 0 and reg_we_o = 0.
- Divide FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY when aluOp_i is a divide op and flush_i = 0.
  - On entry, latch |op1|, |op2|, the result signs, the opcode, reg_waddr_i and reg_we_i; clear the counter.
- BUSY: one restoring-division step per cycle.
  - Shift remainder:quotient left by one, trial-subtract the divisor, set the quotient bit.
  - After DIV_CYCLES steps, go to DONE.
- DONE: present the result with sign correction applied, then go to IDLE unconditionally. The same op still sitting on the inputs does not restart the divider.
- Sign rules:
  - Quotient is negative iff the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - DIVU and REMU use no sign correction.
- Special cases (BUSY lasts 1 cycle, then DONE):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- stall_o = 1 in two cases: in IDLE when a divide op is presented (and flush_i = 0), and throughout BUSY. stall_o = 0 in DONE.
- reg_we_o = 0 while stall_o = 1, so EXE/MEM receives a bubble.
- flush_i = 1 in any state:
  - next state is IDLE, reg_we_o = 0 that cycle, stall_o = 0;
  - flush takes priority over a divide start and over DONE.
- Reset (rst_i = 0, any time, including mid-divide):
  - state = IDLE, counter = 0, latched registers = 0;
  - while asserted, wdata_o = 0, reg_we_o = 0, reg_waddr_o = 0, stall_o = 0.

## Timing
- Single-cycle ops: zero-cycle latency; outputs are valid in the same cycle as the inputs.
- Normal divide, with cycle 0 being the cycle the op arrives in IDLE:
  - stall_o = 1 in cycles 0–32;
  - result valid in cycle 33 (DONE) with stall_o = 0;
  - the next instruction enters EXE in cycle 34.
- Special-case divide: stall_o = 1 in cycles 0–1; result in cycle 2.
- Back-to-back divides: the second starts in the cycle after DONE. There is no bubble beyond the FSM's own occupancy.
- Upstream must hold its inputs stable while stall_o = 1. The block relies only on its latched copies after cycle 0.

## Structure
- Shared package holds:
  - XLEN, the register-address width and the 8-bit aluOp encodings (including NOP and the MUL/DIV groups);
  - ZeroWord, WriteDisable and ZeroReg;
  - the FSM state encoding.
- One sub-module, div_iter: the serial unsigned divider plus its counter, with start/done handshake, flush and asynchronous reset.
- ex_stage keeps the combinational ALU, the multiplier, sign handling and stall logic.

## Test plan
- ADD 0x7FFFFFFF + 1, then SRA 0x80000000 >> 4 → 0x80000000 and 0xF8000000, each in the same cycle with stall_o = 0.
- DIV -7 / 2 and REM -7 / 2 → 0xFFFFFFFD and 0xFFFFFFFF; stall_o high for exactly 33 cycles; reg_we_o only in cycle 33.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF → 0; both in cycle 2.
- flush_i asserted in cycle 10 of a DIVU → next cycle IDLE and stall_o = 0; no reg_we_o is produced for that instruction.
- rst_i pulsed low in cycle 15 of a DIV → all outputs 0 at once; after release, a following ADD 3 + 4 = 7 completes normally.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; DIV followed immediately by DIV → second result in cycle 67.
